stack_ram: RTL and testbench
============================

# stack_ram

Parametrised RAM-backed LIFO stack for the stack-calculator datapath. It is the next generation of the plain 128x8 single-port memory: width and depth are parameters, and a stack pointer with push/pop/replace/peek/clear operations is built in. Full/empty/count status and sticky error flags are provided. It sits between the controller and the display/LED logic, and replaces the separate address-driven memory plus controller-side pointer arithmetic.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 7: address width; depth `DEPTH` = 2^ADDR_W (default 128).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cs`  in  1  chip select; when 0, all ops are ignored and state holds.
- `push`  in  1  push `din` onto the stack.
- `pop`  in  1  pop the top entry to `dout`.
- `peek`  in  1  read the entry `peek_off` below the top, without changing the stack.
- `peek_off`  in  ADDR_W  peek offset; 0 = top of stack.
- `clr`  in  1  empty the stack (count to 0); RAM contents untouched.
- `clr_err`  in  1  clear the sticky error flags.
- `din`  in  DATA_W  push data.
- `dout`  out  DATA_W  registered read data.
- `dout_valid`  out  1  one-cycle pulse: `dout` was updated this cycle.
- `count`  out  ADDR_W+1  number of entries held, 0..DEPTH.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `err_ovf`  out  1  sticky: a push was rejected.
- `err_udf`  out  1  sticky: a pop, replace or peek was rejected.

## Operation
- Storage is `DEPTH` x `DATA_W`. The stack grows downward from address DEPTH-1.
  - Entry i (0 = bottom) lives at address DEPTH-1-i.
  - Top lives at address DEPTH-count.
  - Next push writes to address DEPTH-1-count.
- Ops are sampled only when `cs`=1. Priority: `clr` > `push`/`pop` > `peek`. Lower-priority ops in the same cycle are ignored without error.
- `clr`: count <= 0; dout_valid = 0; no error.
- `push` only:
  - Not full: write `din` at DEPTH-1-count; count += 1.
  - Full: write suppressed; count unchanged; err_ovf <= 1.
- `pop` only:
  - Not empty: dout <= top; count -= 1; dout_valid pulses.
  - Empty: no change; err_udf <= 1; dout_valid = 0.
- `push`+`pop` (replace):
  - Not empty: dout <= old top; top entry <= `din`; count unchanged; dout_valid pulses. This is legal when full.
  - Empty: nothing pushed; err_udf <= 1.
- `peek`:
  - peek_off < count: dout <= entry at address DEPTH-count+peek_off; dout_valid pulses.
  - Otherwise: no read; err_udf <= 1.
- `clr_err`: clears both flags. It is independent of `cs`. It loses to a same-cycle new error, so the flag stays set.
- Count arithmetic is ADDR_W+1 bits. Address arithmetic is modulo 2^ADDR_W. No wrap-around of the stack ever occurs; bounds checks prevent it.
- `dout` holds its last value when no read is accepted.

## Timing
- Reset (async, immediate): count=0, empty=1, full=0, dout=0, dout_valid=0, err_ovf=0, err_udf=0. RAM is not initialised.
- Reset asserted mid-op: the in-flight op is discarded. If reset coincides with the edge, no write lands.
- Read latency is 1 cycle. For pop, replace or peek accepted at edge N, dout and dout_valid are valid after edge N; dout_valid falls after edge N+1 unless another read is accepted.
- The write and the count update take effect at the same edge.
  - A push at edge N is visible to a pop or peek at edge N+1. There is no bypass hazard, because reads use the updated pointer.
- Replace performs its read (old top) and write (new top) at the same address in one edge; dout must return the old value (read-before-write).
- count/empty/full are registered and change only at the accepting edge.
- Error flags set at the edge that rejects the op.
- Throughput: one op per cycle, back-to-back with no stalls.

## Test plan
All scenarios use ADDR_W=2 (DEPTH=4) and DATA_W=8.
1. After reset, push 0x11, 0x22, 0x33, 0x44 -> count=4, full=1. A 5th push of 0x55 -> err_ovf=1, count stays 4. Then pop x4 -> dout 0x44, 0x33, 0x22, 0x11, one per cycle with dout_valid each, and empty=1.
2. Pop when empty -> err_udf=1, dout_valid=0, dout unchanged. Then clr_err -> both flags 0.
3. Push 0x0A, 0x0B, then push+pop with din=0xCC -> dout=0x0B, count=2. Then pop -> 0xCC.
4. Push 0x01, 0x02, 0x03. Peek off=0 -> 0x03; off=2 -> 0x01; off=3 -> err_udf=1 and count stays 3.
5. Push 0x77 with cs=0 -> count stays 0. clr with push+pop in the same cycle on a 3-deep stack -> count=0, no error. Assert rst mid-stream -> all outputs at reset values immediately.
6. Alternate push and pop every cycle for 20 cycles with random data -> each pop returns the previous push, and count toggles 1/0.

Source files
------------

// File: rtl/stack_ram_if.sv
// Handshake/data bundle for the RAM-backed LIFO stack.
// The controller is the master; the stack is the slave.
interface stack_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              cs;
    logic              push;
    logic              pop;
    logic              peek;
    logic [ADDR_W-1:0] peek_off;
    logic              clr;
    logic              clr_err;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              err_ovf;
    logic              err_udf;

    modport master (
        output cs, push, pop, peek, peek_off, clr, clr_err, din,
        input  dout, dout_valid, count, empty, full, err_ovf, err_udf
    );

    modport slave (
        input  cs, push, pop, peek, peek_off, clr, clr_err, din,
        output dout, dout_valid, count, empty, full, err_ovf, err_udf
    );
endinterface

// File: rtl/stack_ram.sv
// RAM-backed LIFO stack growing downward from address DEPTH-1,
// with push/pop/replace/peek/clear and sticky error flags.
module stack_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic       clk,
    input  logic       rst,
    stack_ram_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              full, empty;
    logic              op_push, op_pop, op_rep, op_peek;
    logic              push_ok, pop_ok, rep_ok, peek_ok, peek_in;
    logic              ovf_set, udf_set, rd_en, wr_en;
    logic [ADDR_W-1:0] top_a, push_a, peek_a, rd_a, wr_a;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // Modulo-DEPTH addressing: top = DEPTH-count, next free = DEPTH-1-count
    assign top_a  = '0 - count_q[ADDR_W-1:0];
    assign push_a = ~count_q[ADDR_W-1:0];
    assign peek_a = top_a + bus.peek_off;

    assign op_push = bus.cs && !bus.clr && bus.push && !bus.pop;
    assign op_pop  = bus.cs && !bus.clr && bus.pop && !bus.push;
    assign op_rep  = bus.cs && !bus.clr && bus.push && bus.pop;
    assign op_peek = bus.cs && !bus.clr && !bus.push && !bus.pop
                     && bus.peek;
    assign peek_in = ({1'b0, bus.peek_off} < count_q);

    assign push_ok = op_push && !full;
    assign pop_ok  = op_pop && !empty;
    assign rep_ok  = op_rep && !empty;
    assign peek_ok = op_peek && peek_in;

    assign ovf_set = op_push && full;
    assign udf_set = ((op_pop || op_rep) && empty)
                     || (op_peek && !peek_in);

    assign rd_en = pop_ok || rep_ok || peek_ok;
    assign rd_a  = peek_ok ? peek_a : top_a;
    assign wr_en = push_ok || rep_ok;
    assign wr_a  = push_ok ? push_a : top_a;

    always_comb begin
        count_d = count_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (bus.cs && bus.clr) begin
            count_d = '0;
        end else if (push_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok) begin
            count_d = count_q - 1'b1;
        end
        if (rd_en) begin
            dout_d = mem_q[rd_a];
            dv_d   = 1'b1;
        end
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (udf_set) udf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset; replace reads the old top before it is overwritten
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_a] <= bus.din;
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.err_ovf    = ovf_q;
    assign bus.err_udf    = udf_q;
endmodule

// File: tb/tb_stack_ram.sv
// Scoreboard bench for stack_ram at DEPTH=4, DATA_W=8 against a
// queue-based stack model.
module tb_stack_ram;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stack_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    stack_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] stk [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_udf, m_rd;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: stack semantics from the operation rules, not the RTL
    task automatic model(input bit cs, input bit pu, input bit po,
                         input bit pk, input int off, input bit cl,
                         input bit ce, input logic [DW-1:0] d);
        bit ovf_s, udf_s;
        ovf_s = 0;
        udf_s = 0;
        m_rd  = 0;
        if (cs) begin
            if (cl) begin
                stk.delete();
            end else if (pu && po) begin
                if (stk.size() == 0) udf_s = 1;
                else begin
                    m_dout = stk[stk.size()-1];
                    m_rd = 1;
                    stk[stk.size()-1] = d;
                end
            end else if (pu) begin
                if (stk.size() == DEPTH) ovf_s = 1;
                else stk.push_back(d);
            end else if (po) begin
                if (stk.size() == 0) udf_s = 1;
                else begin
                    m_dout = stk.pop_back();
                    m_rd = 1;
                end
            end else if (pk) begin
                if (off < stk.size()) begin
                    m_dout = stk[stk.size()-1-off];
                    m_rd = 1;
                end else udf_s = 1;
            end
        end
        if (ce) begin
            m_ovf = 0;
            m_udf = 0;
        end
        m_ovf |= ovf_s;
        m_udf |= udf_s;
        if (m_rd) exp_q.push_back(m_dout);
    endtask

    task automatic step(input bit cs, input bit pu, input bit po,
                        input bit pk, input int off, input bit cl,
                        input bit ce, input logic [DW-1:0] d);
        bus.cs       = cs;
        bus.push     = pu;
        bus.pop      = po;
        bus.peek     = pk;
        bus.peek_off = AW'(off);
        bus.clr      = cl;
        bus.clr_err  = ce;
        bus.din      = d;
        @(posedge clk);
        model(cs, pu, po, pk, off, cl, ce, d);
        #1;
        chk("count", int'(bus.count), stk.size());
        chk("empty", int'(bus.empty), int'(stk.size() == 0));
        chk("full", int'(bus.full), int'(stk.size() == DEPTH));
        chk("err_ovf", int'(bus.err_ovf), int'(m_ovf));
        chk("err_udf", int'(bus.err_udf), int'(m_udf));
        chk("dout_valid", int'(bus.dout_valid), int'(m_rd));
        chk("dout", int'(bus.dout), int'(m_dout));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: every dout_valid pulse must match the oldest expected read
    always @(negedge clk) begin
        if (!rst && bus.dout_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected none",
                         bus.dout);
            end else begin
                chk("sb_dout", int'(bus.dout), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [DW-1:0] r;
        bus.cs = 0; bus.push = 0; bus.pop = 0; bus.peek = 0;
        bus.peek_off = '0; bus.clr = 0; bus.clr_err = 0; bus.din = '0;
        m_dout = '0; m_ovf = 0; m_udf = 0; m_rd = 0;
        rst = 1;
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_dout", int'(bus.dout), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: fill, overflow, drain
        step(1, 1, 0, 0, 0, 0, 0, 8'h11);
        step(1, 1, 0, 0, 0, 0, 0, 8'h22);
        step(1, 1, 0, 0, 0, 0, 0, 8'h33);
        step(1, 1, 0, 0, 0, 0, 0, 8'h44);
        step(1, 1, 0, 0, 0, 0, 0, 8'h55);
        repeat (4) step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        // 2: underflow then clear flags
        step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        // 3: replace
        step(1, 1, 0, 0, 0, 0, 0, 8'h0A);
        step(1, 1, 0, 0, 0, 0, 0, 8'h0B);
        step(1, 1, 1, 0, 0, 0, 0, 8'hCC);
        step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        // 4: peek
        step(1, 1, 0, 0, 0, 0, 0, 8'h01);
        step(1, 1, 0, 0, 0, 0, 0, 8'h02);
        step(1, 1, 0, 0, 0, 0, 0, 8'h03);
        step(1, 0, 0, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 2, 0, 0, 8'h00);
        step(1, 0, 0, 1, 3, 0, 0, 8'h00);
        // clr_err loses to a same-cycle new error
        step(1, 0, 0, 1, 3, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 0, 1, 8'h00);
        // 5: cs gating, clr priority, async reset
        step(1, 0, 0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 0, 0, 0, 8'h77);
        step(1, 1, 0, 0, 0, 0, 0, 8'h0D);
        step(1, 1, 0, 0, 0, 0, 0, 8'h0E);
        step(1, 1, 0, 0, 0, 0, 0, 8'h0F);
        step(1, 1, 1, 0, 0, 1, 0, 8'h99);
        step(1, 1, 0, 0, 0, 0, 0, 8'h21);
        step(1, 1, 1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 1, 0, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_count", int'(bus.count), 0);
        chk("arst_empty", int'(bus.empty), 1);
        chk("arst_full", int'(bus.full), 0);
        chk("arst_dout", int'(bus.dout), 0);
        chk("arst_dv", int'(bus.dout_valid), 0);
        chk("arst_ovf", int'(bus.err_ovf), 0);
        chk("arst_udf", int'(bus.err_udf), 0);
        stk.delete();
        exp_q.delete();
        m_dout = '0; m_ovf = 0; m_udf = 0;
        @(posedge clk);
        #1 rst = 0;

        // 6: alternating push/pop with random data
        for (int i = 0; i < 10; i++) begin
            r = DW'($urandom);
            step(1, 1, 0, 0, 0, 0, 0, r);
            step(1, 0, 1, 0, 0, 0, 0, 8'h00);
        end

        // random mixed traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, DEPTH-1), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0), DW'($urandom));
        end
        idle();
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
